// File: rtl/toggle_monitor_pkg.sv
// Shared types and defaults for the toggle monitor.
package toggle_monitor_pkg;

    localparam int unsigned CNT_W_DEF = 26;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        TRACK      = 2'd1,
        LOST       = 2'd2
    } state_e;

endpackage

// File: rtl/toggle_monitor_sync_edge_det.sv
// Synchronizer, optional glitch filter (GLITCH_FILTER_EN) and registered edge detector.
// edge_pulse_o rises 3 cycles after a din_i change (3+FILT_LEN with the filter).
module sync_edge_det
`ifdef GLITCH_FILTER_EN
#(
    parameter int unsigned FILT_LEN = 4
)
`endif
(
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic din_i,
    output logic edge_pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;
    logic level;

`ifdef GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILT_LEN + 1);

    logic           filt_q;
    logic [FCW-1:0] fcnt_q;

    // The filtered level only follows sync2 after FILT_LEN consecutive differing samples.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FCW'(FILT_LEN - 1)) begin
            filt_q <= sync2_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + FCW'(1);
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            prev_q  <= level;
            edge_q  <= level ^ prev_q;
        end
    end

    assign edge_pulse_o = edge_q;

endmodule

// File: rtl/toggle_monitor.sv
// Measures the cycle distance between edges of a looped-back toggle and checks it against
// CNT_MAX+1. Optional input glitch filter enabled with GLITCH_FILTER_EN.
module toggle_monitor
    import toggle_monitor_pkg::*;
#(
    parameter logic [24:0]       CNT_MAX     = 25'd24_999_999,
    parameter int unsigned       CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0]  TOL         = CNT_W'(1000),
    parameter logic [2:0]        LOCK_CNT    = 3'd4,
    parameter logic [CNT_W-1:0]  TIMEOUT_CYC = CNT_W'(50_000_000)
`ifdef GLITCH_FILTER_EN
    ,
    parameter int unsigned       FILT_LEN    = 4
`endif
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic             sig_in_i,
    output logic             edge_pulse_o,
    output logic             meas_valid_o,
    output logic [CNT_W-1:0] meas_cnt_o,
    output logic             in_tol_o,
    output logic             locked_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] EXP_HALF = CNT_W'(CNT_MAX) + CNT_W'(1);

    logic             edge_det;
    state_e           state_q;
    logic [CNT_W-1:0] gap_q;
    logic [2:0]       good_q;
    logic             meas_valid_q;
    logic [CNT_W-1:0] meas_cnt_q;
    logic             in_tol_q;
    logic             locked_q;
    logic             timeout_q;

    logic [CNT_W-1:0] meas;
    logic [CNT_W-1:0] diff;
    logic             meas_ok;
    logic [2:0]       good_inc;

    sync_edge_det
`ifdef GLITCH_FILTER_EN
    #(
        .FILT_LEN (FILT_LEN)
    )
`endif
    u_sync_edge_det (
        .sys_clk_i    (sys_clk_i),
        .sys_rst_i    (sys_rst_i),
        .din_i        (sig_in_i),
        .edge_pulse_o (edge_det)
    );

    // Unsigned absolute difference: larger minus smaller.
    always_comb begin
        meas     = gap_q + CNT_W'(1);
        diff     = (meas >= EXP_HALF) ? (meas - EXP_HALF) : (EXP_HALF - meas);
        meas_ok  = (diff <= TOL);
        good_inc = (good_q == LOCK_CNT) ? LOCK_CNT : (good_q + 3'd1);
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q      <= WAIT_FIRST;
            gap_q        <= '0;
            good_q       <= '0;
            meas_valid_q <= 1'b0;
            meas_cnt_q   <= '0;
            in_tol_q     <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;

            if (edge_det) begin
                gap_q <= '0;
            end else if (gap_q < TIMEOUT_CYC) begin
                gap_q <= gap_q + CNT_W'(1);
            end

            // An edge always takes precedence over a coincident timeout.
            case (state_q)
                WAIT_FIRST: begin
                    if (edge_det) begin
                        state_q   <= TRACK;
                        timeout_q <= 1'b0;
                    end else if (gap_q == TIMEOUT_CYC) begin
                        timeout_q <= 1'b1;
                    end
                end
                TRACK: begin
                    if (edge_det) begin
                        meas_valid_q <= 1'b1;
                        meas_cnt_q   <= meas;
                        in_tol_q     <= meas_ok;
                        if (meas_ok) begin
                            good_q   <= good_inc;
                            locked_q <= (good_inc == LOCK_CNT);
                        end else begin
                            good_q   <= '0;
                            locked_q <= 1'b0;
                        end
                    end else if (gap_q == TIMEOUT_CYC) begin
                        state_q   <= LOST;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        good_q    <= '0;
                    end
                end
                LOST: begin
                    if (edge_det) begin
                        state_q   <= TRACK;
                        timeout_q <= 1'b0;
                    end
                end
                default: state_q <= WAIT_FIRST;
            endcase
        end
    end

    assign edge_pulse_o = edge_det;
    assign meas_valid_o = meas_valid_q;
    assign meas_cnt_o   = meas_cnt_q;
    assign in_tol_o     = in_tol_q;
    assign locked_o     = locked_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed self-checking bench for toggle_monitor (CNT_MAX=9, TOL=1, LOCK_CNT=4, TIMEOUT=40).
module tb_toggle_monitor;

`ifdef GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sig;
    logic        edge_pulse;
    logic        meas_valid;
    logic [25:0] meas_cnt;
    logic        in_tol;
    logic        locked;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    toggle_monitor #(
        .CNT_MAX     (25'd9),
        .CNT_W       (26),
        .TOL         (26'd1),
        .LOCK_CNT    (3'd4),
        .TIMEOUT_CYC (26'd40)
    ) dut (
        .sys_clk_i    (clk),
        .sys_rst_i    (rst),
        .sig_in_i     (sig),
        .edge_pulse_o (edge_pulse),
        .meas_valid_o (meas_valid),
        .meas_cnt_o   (meas_cnt),
        .in_tol_o     (in_tol),
        .locked_o     (locked),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Toggle sig, check the edge latency and the resulting measurement, then idle so the
    // next toggle lands `hold` cycles after this one.
    task automatic edge_step(input string tag, input int hold, input bit exp_mv,
                             input int exp_cnt, input bit exp_tol, input bit exp_lock);
        sig = ~sig;
        repeat (LAT - 1) tick();
        check_eq({tag, ".edge_early"}, 32'(edge_pulse), 0);
        tick();
        check_eq({tag, ".edge"}, 32'(edge_pulse), 1);
        tick();
        check_eq({tag, ".meas_valid"}, 32'(meas_valid), 32'(exp_mv));
        if (exp_mv) begin
            check_eq({tag, ".meas_cnt"}, 32'(meas_cnt), 32'(exp_cnt));
            check_eq({tag, ".in_tol"}, 32'(in_tol), 32'(exp_tol));
        end
        check_eq({tag, ".locked"}, 32'(locked), 32'(exp_lock));
        check_eq({tag, ".timeout"}, 32'(timeout), 0);
        repeat (hold - LAT - 1) tick();
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        sig = 1'b0;
        repeat (5) begin
            sig = ~sig;
            tick();
        end
        check_eq("rst.edge_pulse", 32'(edge_pulse), 0);
        check_eq("rst.meas_valid", 32'(meas_valid), 0);
        check_eq("rst.meas_cnt", 32'(meas_cnt), 0);
        check_eq("rst.in_tol", 32'(in_tol), 0);
        check_eq("rst.locked", 32'(locked), 0);
        check_eq("rst.timeout", 32'(timeout), 0);

        sig = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | edge_pulse;
        end
        check_eq("release.no_edge", 32'(seen), 0);

`ifdef GLITCH_FILTER_EN
        sig = 1'b1;
        tick();
        tick();
        sig = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen = seen | edge_pulse;
        end
        check_eq("glitch.no_edge", 32'(seen), 0);
`endif

        // Nominal lock: first edge has no measurement, lock on the 4th measurement.
        edge_step("e1", 10, 0, 0, 0, 0);
        for (int i = 2; i <= 4; i++) begin
            edge_step($sformatf("e%0d", i), 10, 1, 10, 1, 0);
        end
        edge_step("e5", 10, 1, 10, 1, 1);
        edge_step("e6", 11, 1, 10, 1, 1);

        // Tolerance: 11 and 9 sit exactly on the bounds, 12 and 8 fall outside.
        edge_step("tol11", 9, 1, 11, 1, 1);
        edge_step("tol9", 12, 1, 9, 1, 1);
        edge_step("tol12", 8, 1, 12, 0, 0);
        edge_step("tol8", 10, 1, 8, 0, 0);

        // Relock, then stop toggling.
        for (int i = 11; i <= 13; i++) begin
            edge_step($sformatf("e%0d", i), 10, 1, 10, 1, 0);
        end
        edge_step("e14", LAT + 1, 1, 10, 1, 1);

        // Edge consumed at tick LAT+1; gap reaches 40 at tick LAT+41, timeout at LAT+42.
        repeat (40) tick();
        check_eq("to.before", 32'(timeout), 0);
        check_eq("to.locked_before", 32'(locked), 1);
        tick();
        check_eq("to.after", 32'(timeout), 1);
        check_eq("to.locked_after", 32'(locked), 0);
        repeat (5) tick();
        check_eq("to.held", 32'(timeout), 1);

        // Recovery edge takes no measurement; the next gap of 41 coincides with the limit.
        edge_step("recover", 41, 0, 0, 0, 0);
        edge_step("coincide", 10, 1, 41, 0, 0);

        // Reset mid-measurement clears everything.
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst.meas_cnt", 32'(meas_cnt), 0);
        check_eq("midrst.in_tol", 32'(in_tol), 0);
        check_eq("midrst.timeout", 32'(timeout), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
